sprite_motion_ctrl: RTL and testbench

- Upstream position/state source for the paletted two-image sprite renderer.
- Once per frame, during vertical blanking, it computes the sprite's top-left position (x_out, y_out) and the image-select flag (pop_out), which feed that renderer's x_in, y_in and pop_in.
- Implements bouncing motion inside the screen plus a timed "pop" animation sequence with a cooldown.
- All outputs change only at the frame tick, so the renderer never sees a mid-frame change.

---
 rtl/sprite_motion_ctrl.sv | 174 +++++++++++++++++
 tb/tb_sprite_motion_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_motion_ctrl.sv
// Per-frame sprite position and pop-image controller.
// Updates once per frame at the blanking tick; drives renderer x/y/pop.
module sprite_motion_ctrl #(
  parameter int SPRITE_W   = 256,
  parameter int SPRITE_H   = 256,
  parameter int SCREEN_W   = 1280,
  parameter int SCREEN_H   = 720,
  parameter int POP_FRAMES = 8
) (
  input  logic        pixel_clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        enable_in,
  input  logic [3:0]  speed_in,
  input  logic        trigger_in,
  output logic [10:0] x_out,
  output logic [9:0]  y_out,
  output logic        pop_out,
  output logic        frame_tick_out,
  output logic [7:0]  bounce_count_out
);

  localparam logic [11:0] X_MAX = 12'(SCREEN_W - SPRITE_W);
  localparam logic [10:0] Y_MAX = 11'(SCREEN_H - SPRITE_H);
  localparam logic [7:0]  LAST  = 8'(POP_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE,
    POP,
    COOL
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic        dir_x, dir_x_nxt;
  logic        dir_y, dir_y_nxt;
  logic        trig_pend, pend_nxt;
  logic [10:0] x_nxt;
  logic [9:0]  y_nxt;
  logic [7:0]  bc_nxt;

  logic        tick, run, moving, bounce, clr;
  logic [11:0] nx;
  logic [10:0] ny;
  logic [10:0] x_mv;
  logic [9:0]  y_mv;
  logic        fx, fy;

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      state            <= IDLE;
      cnt              <= '0;
      dir_x            <= 1'b0;
      dir_y            <= 1'b0;
      trig_pend        <= 1'b0;
      x_out            <= '0;
      y_out            <= '0;
      pop_out          <= 1'b0;
      frame_tick_out   <= 1'b0;
      bounce_count_out <= '0;
    end else begin
      state            <= state_nxt;
      cnt              <= cnt_nxt;
      dir_x            <= dir_x_nxt;
      dir_y            <= dir_y_nxt;
      trig_pend        <= pend_nxt;
      x_out            <= x_nxt;
      y_out            <= y_nxt;
      pop_out          <= (state_nxt == POP);
      frame_tick_out   <= tick;
      bounce_count_out <= bc_nxt;
    end
  end

  always_comb begin
    tick = (hcount_in == 11'(SCREEN_W)) && (vcount_in == 10'(SCREEN_H));
    run = tick && enable_in;
    moving = run && (state != POP);

    nx = {1'b0, x_out} + {8'b0, speed_in};
    ny = {1'b0, y_out} + {7'b0, speed_in};
    x_mv = x_out;
    y_mv = y_out;
    fx = 1'b0;
    fy = 1'b0;

    // Zero speed must neither move nor flip, even parked on a wall
    if (speed_in != 4'd0) begin
      if (!dir_x) begin
        if (nx >= X_MAX) begin
          x_mv = X_MAX[10:0];
          fx = 1'b1;
        end else begin
          x_mv = nx[10:0];
        end
      end else if (x_out <= {7'b0, speed_in}) begin
        x_mv = '0;
        fx = 1'b1;
      end else begin
        x_mv = x_out - {7'b0, speed_in};
      end

      if (!dir_y) begin
        if (ny >= Y_MAX) begin
          y_mv = Y_MAX[9:0];
          fy = 1'b1;
        end else begin
          y_mv = ny[9:0];
        end
      end else if (y_out <= {6'b0, speed_in}) begin
        y_mv = '0;
        fy = 1'b1;
      end else begin
        y_mv = y_out - {6'b0, speed_in};
      end
    end

    bounce = moving && (fx || fy);

    x_nxt = x_out;
    y_nxt = y_out;
    dir_x_nxt = dir_x;
    dir_y_nxt = dir_y;
    bc_nxt = bounce_count_out;
    if (moving) begin
      x_nxt = x_mv;
      y_nxt = y_mv;
      dir_x_nxt = dir_x ^ fx;
      dir_y_nxt = dir_y ^ fy;
    end
    if (bounce && (bounce_count_out != 8'hFF)) begin
      bc_nxt = bounce_count_out + 8'd1;
    end

    // A trigger landing on the clearing edge survives for the next frame
    clr = tick && (((state == IDLE) && enable_in) || (state == COOL));
    pend_nxt = trigger_in || (trig_pend && !clr);

    state_nxt = state;
    cnt_nxt = cnt;
    if (run) begin
      unique case (state)
        IDLE: begin
          if (trig_pend || bounce) begin
            state_nxt = POP;
            cnt_nxt = '0;
          end
        end
        POP: begin
          if (cnt == LAST) begin
            state_nxt = COOL;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end
        COOL: begin
          if (cnt == LAST) begin
            state_nxt = IDLE;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Bench for sprite_motion_ctrl: behavioural model plus directed
// frame sequences and randomized timing/enable/trigger stimulus.
module tb_sprite_motion_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [10:0] hcount = '0;
  logic [9:0]  vcount = '0;
  logic        enable = 1'b0;
  logic [3:0]  speed = '0;
  logic        trigger = 1'b0;
  logic [10:0] x_out;
  logic [9:0]  y_out;
  logic        pop_out;
  logic        frame_tick_out;
  logic [7:0]  bounce_count_out;

  bit run_clk = 1'b0;
  bit chk_on = 1'b0;
  int n_chk = 0;
  int n_pass = 0;

  // model state: mode 0 idle, 1 pop, 2 cooldown
  int m_x, m_y, m_dx, m_dy, m_mode, m_left, m_bc, m_ft, m_pend, m_events;

  sprite_motion_ctrl dut (
    .pixel_clk_in    (clk),
    .rst_in          (rst),
    .hcount_in       (hcount),
    .vcount_in       (vcount),
    .enable_in       (enable),
    .speed_in        (speed),
    .trigger_in      (trigger),
    .x_out           (x_out),
    .y_out           (y_out),
    .pop_out         (pop_out),
    .frame_tick_out  (frame_tick_out),
    .bounce_count_out(bounce_count_out)
  );

  always #5 clk = run_clk ? ~clk : clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
  endtask

  task automatic axis(inout int p, inout int d, input int s,
                      input int mx, output bit f);
    int np;
    f = 1'b0;
    if (s == 0) return;
    np = p + d * s;
    if (np >= mx) begin
      p = mx; d = -1; f = 1'b1;
    end else if (np <= 0) begin
      p = 0; d = 1; f = 1'b1;
    end else begin
      p = np;
    end
  endtask

  task automatic model_reset();
    m_x = 0; m_y = 0; m_dx = 1; m_dy = 1;
    m_mode = 0; m_left = 0; m_bc = 0; m_ft = 0; m_pend = 0;
  endtask

  task automatic model_step();
    bit tk, clear, fx, fy, bnc;
    int np;
    tk = (hcount == 11'd1280) && (vcount == 10'd720);
    clear = tk && ((m_mode == 0 && enable) || m_mode == 2);
    np = (trigger || (m_pend != 0 && !clear)) ? 1 : 0;
    bnc = 1'b0;
    if (tk && enable) begin
      if (m_mode != 1) begin
        axis(m_x, m_dx, int'(speed), 1024, fx);
        axis(m_y, m_dy, int'(speed), 464, fy);
        bnc = fx | fy;
        if (bnc) begin
          m_events++;
          if (m_bc < 255) m_bc++;
        end
      end
      case (m_mode)
        0: if (m_pend != 0 || bnc) begin m_mode = 1; m_left = 8; end
        1: begin m_left--; if (m_left == 0) begin m_mode = 2; m_left = 8; end end
        default: begin m_left--; if (m_left == 0) m_mode = 0; end
      endcase
    end
    m_pend = np;
    m_ft = tk ? 1 : 0;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("x", int'(x_out), m_x);
      chk("y", int'(y_out), m_y);
      chk("pop", int'(pop_out), (m_mode == 1) ? 1 : 0);
      chk("tick", int'(frame_tick_out), m_ft);
      chk("bounces", int'(bounce_count_out), m_bc);
    end
  end

  task automatic tick(input bit en, input int spd);
    @(negedge clk);
    hcount = 11'd1280; vcount = 10'd720;
    enable = en; speed = 4'(spd);
    @(negedge clk);
    hcount = '0; vcount = '0; trigger = 1'b0;
  endtask

  task automatic pulse();
    @(negedge clk);
    hcount = '0; vcount = '0; trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
  endtask

  initial begin
    m_events = 0;
    model_reset();
    #1 rst = 1'b1;
    #10;
    chk("rst_x", int'(x_out), 0);
    chk("rst_y", int'(y_out), 0);
    chk("rst_pop", int'(pop_out), 0);
    chk("rst_tick", int'(frame_tick_out), 0);
    chk("rst_bc", int'(bounce_count_out), 0);
    run_clk = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_on = 1'b1;

    tick(1'b1, 4);
    chk("first_x", int'(x_out), 4);
    chk("first_y", int'(y_out), 4);
    chk("first_tick_hi", int'(frame_tick_out), 1);
    @(negedge clk);
    chk("first_tick_lo", int'(frame_tick_out), 0);

    repeat (30) tick(1'b1, 15);
    chk("pre_wall_y", int'(y_out), 454);
    chk("pre_wall_x", int'(x_out), 454);
    tick(1'b1, 15);
    chk("wall_y", int'(y_out), 464);
    chk("wall_x", int'(x_out), 469);
    chk("wall_pop", int'(pop_out), 1);
    chk("wall_bc", int'(bounce_count_out), 1);
    for (int i = 0; i < 7; i++) begin
      tick(1'b1, 15);
      chk("pop_hold", int'(pop_out), 1);
      chk("pop_frozen", int'(x_out), 469);
    end
    tick(1'b1, 15);
    chk("pop_end", int'(pop_out), 0);
    chk("pop_end_x", int'(x_out), 469);
    tick(1'b1, 15);
    chk("resume_x", int'(x_out), 484);
    chk("resume_y", int'(y_out), 449);

    pulse();
    for (int i = 0; i < 7; i++) begin
      tick(1'b1, 15);
      chk("cool_pop", int'(pop_out), 0);
    end
    chk("cool_x", int'(x_out), 589);
    chk("cool_y", int'(y_out), 344);
    tick(1'b1, 15);
    chk("discard_pop", int'(pop_out), 0);
    chk("discard_x", int'(x_out), 604);
    chk("discard_y", int'(y_out), 329);

    pulse();
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 15);
      chk("hold_tick", int'(frame_tick_out), 1);
      chk("hold_x", int'(x_out), 604);
      chk("hold_y", int'(y_out), 329);
      chk("hold_pop", int'(pop_out), 0);
    end
    tick(1'b1, 15);
    chk("pend_pop", int'(pop_out), 1);
    chk("pend_x", int'(x_out), 619);
    chk("pend_y", int'(y_out), 314);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 2) == 0) begin
        hcount = 11'd1280; vcount = 10'd720;
      end else if ($urandom_range(0, 9) == 0) begin
        hcount = 11'h7FF; vcount = 10'h3FF;
      end else begin
        hcount = 11'($urandom_range(1276, 1284));
        vcount = 10'($urandom_range(716, 724));
      end
      enable = ($urandom_range(0, 9) != 0);
      speed = 4'($urandom_range(0, 15));
      trigger = ($urandom_range(0, 9) == 0);
    end
    @(negedge clk);
    hcount = '0; vcount = '0; trigger = 1'b0;

    for (int i = 0; i < 15000 && m_events < 300; i++) tick(1'b1, 15);
    chk("sat_events", (m_events >= 300) ? 1 : 0, 1);
    chk("sat_bc", int'(bounce_count_out), 255);

    pulse();
    for (int i = 0; i < 60 && m_mode != 1; i++) tick(1'b1, 15);
    chk("pre_rst_pop", int'(pop_out), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_pop", int'(pop_out), 0);
    chk("async_x", int'(x_out), 0);
    chk("async_bc", int'(bounce_count_out), 0);
    @(negedge clk);
    rst = 1'b0;
    tick(1'b1, 4);
    chk("post_rst_x", int'(x_out), 4);
    repeat (2) @(negedge clk);
    chk_on = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
